// File: rtl/phase_delay_pkg.sv
// Shared definitions for the phase delay generator: FSM state encoding and
// default widths. Optional PHASE_DELAY_SYNC_EN build adds an input synchronizer.
package phase_delay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2
   } state_t;

   localparam int N_CLK_SIZE_DEF = 8;
   localparam int PHASE_SIZE_DEF = 8;

endpackage

// File: rtl/sig_edge_detect.sv
// Rising-edge strobe for sigIn. With PHASE_DELAY_SYNC_EN defined the input
// first passes through a two-flop synchronizer (adds two cycles of latency).
module sig_edge_detect
   import phase_delay_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic sig_s;
   logic sig_last_reg;

`ifdef PHASE_DELAY_SYNC_EN
   logic [1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[0], sig_in};
      end
   end

   assign sig_s = sync_reg[1];
`else
   assign sig_s = sig_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_last_reg <= 1'b0;
      end else begin
         sig_last_reg <= sig_s;
      end
   end

   assign rise = sig_s & ~sig_last_reg;

endmodule

// File: rtl/phase_delay_gen.sv
// Emits one pulse per sigIn rising edge, delayed by phase/2^PHASE_SIZE of the
// measured period and lasting half the period. See PHASE_DELAY_SYNC_EN in sig_edge_detect.
module phase_delay_gen
   import phase_delay_pkg::*;
#(
   parameter int N_CLK_SIZE = N_CLK_SIZE_DEF,
   parameter int PHASE_SIZE = PHASE_SIZE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sigIn,
   input  logic [N_CLK_SIZE-1:0] n_clk,
   input  logic [PHASE_SIZE-1:0] phase,
   output logic                  sigOut,
   output logic                  busy
);

   localparam int PROD_W = N_CLK_SIZE + PHASE_SIZE;

   logic                  rise;
   logic                  capture;
   logic [PROD_W-1:0]     prod;
   logic [N_CLK_SIZE-1:0] d_calc;
   logic [N_CLK_SIZE-1:0] w_calc;

   state_t                state_reg;
   logic [N_CLK_SIZE-1:0] cnt_reg;
   logic [N_CLK_SIZE-1:0] w_reg;
   logic                  sig_out_reg;
   logic                  busy_reg;

   sig_edge_detect u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sigIn),
      .rise   (rise)
   );

   // Full-width product keeps n_clk*phase exact; D is its upper N_CLK_SIZE bits.
   assign prod    = PROD_W'(n_clk) * PROD_W'(phase);
   assign d_calc  = N_CLK_SIZE'(prod >> PHASE_SIZE);
   assign w_calc  = (n_clk[N_CLK_SIZE-1:1] == '0) ? N_CLK_SIZE'(1) : (n_clk >> 1);
   assign capture = rise && (n_clk != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         w_reg       <= '0;
         sig_out_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else if (capture) begin
         // An accepted edge restarts the sequence from any state.
         w_reg    <= w_calc;
         busy_reg <= 1'b1;
         if (d_calc == '0) begin
            state_reg   <= ST_HIGH;
            cnt_reg     <= w_calc;
            sig_out_reg <= 1'b1;
         end else begin
            state_reg   <= ST_DELAY;
            cnt_reg     <= d_calc;
            sig_out_reg <= 1'b0;
         end
      end else begin
         case (state_reg)
            ST_DELAY: begin
               if (cnt_reg == N_CLK_SIZE'(1)) begin
                  state_reg   <= ST_HIGH;
                  cnt_reg     <= w_reg;
                  sig_out_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_HIGH: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == N_CLK_SIZE'(1)) begin
                  state_reg   <= ST_IDLE;
                  sig_out_reg <= 1'b0;
                  busy_reg    <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign sigOut = sig_out_reg;
   assign busy   = busy_reg;

endmodule

// File: tb/tb_phase_delay_gen.sv
// Scoreboard bench for phase_delay_gen: expected pulses (start cycle, width)
// are queued when an edge is driven and matched by a pulse monitor.
module tb_phase_delay_gen;

`ifdef PHASE_DELAY_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int start;
      int len;
   } pulse_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sigIn;
   logic [7:0] n_clk;
   logic [7:0] phase;
   logic       sigOut;
   logic       busy;

   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   pulse_t exp_q[$];
   bit     mon_prev = 1'b0;
   int     mon_start = 0;

   phase_delay_gen #(.N_CLK_SIZE(8), .PHASE_SIZE(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sigIn  (sigIn),
      .n_clk  (n_clk),
      .phase  (phase),
      .sigOut (sigOut),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: measures each sigOut high run and compares with the queue head.
   always @(negedge clk) begin
      pulse_t p;
      int     len;
      if (sigOut === 1'b1 && !mon_prev) begin
         mon_start = cyc;
      end else if (sigOut !== 1'b1 && mon_prev) begin
         len = cyc - mon_start;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: got start=%0d len=%0d, expected no pulse", mon_start, len);
         end else begin
            p = exp_q.pop_front();
            $display("pulse start=%0d len=%0d (expected start=%0d len=%0d)", mon_start, len, p.start, p.len);
            if (mon_start !== p.start || len !== p.len) begin
               errors++;
               $display("FAIL pulse_timing: got start=%0d len=%0d, expected start=%0d len=%0d",
                        mon_start, len, p.start, p.len);
            end
         end
      end
      mon_prev = (sigOut === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one sigIn rising edge at a negedge, hold it for gap/2, then low to gap.
   task automatic run_edge(input int gap, input int d, input int w,
                           input bit accepted, input bit push, input bit scramble);
      int     e;
      pulse_t p;
      sigIn = 1'b1;
      e = cyc + 1;
      if (push) begin
         p.start = e + d + LAT;
         p.len   = w;
         exp_q.push_back(p);
      end
      repeat (LAT + 1) @(negedge clk);
      checks++;
      if (busy !== accepted) begin
         errors++;
         $display("FAIL busy_after_edge: got %b, expected %b (E=%0d)", busy, accepted, e);
      end
      if (scramble) begin
         n_clk = 8'($urandom);
         phase = 8'($urandom);
      end
      repeat (gap / 2 - LAT - 1) @(negedge clk);
      sigIn = 1'b0;
      repeat (gap - gap / 2) @(negedge clk);
      if (accepted && gap >= d + w + LAT + 1) begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_pulse: got %b, expected 0 (E=%0d)", busy, e);
         end
      end
      $display("edge E=%0d d=%0d w=%0d accepted=%0b gap=%0d", e, d, w, accepted, gap);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sigIn = 1'b0;
      n_clk = 8'd100;
      phase = 8'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sigIn = ~sigIn;
         checks++;
         if (sigOut !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got sigOut=%b busy=%b, expected 0 0", sigOut, busy);
         end
      end
      sigIn = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("reset released at cycle %0d", cyc);
   endtask

   task automatic test_quarter_phase();
      n_clk = 8'd100;
      phase = 8'd64;
      for (int i = 0; i < 3; i++) run_edge(100, 25, 50, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_zero_phase();
      n_clk = 8'd100;
      phase = 8'd0;
      for (int i = 0; i < 2; i++) run_edge(100, 0, 50, 1'b1, 1'b1, 1'b0);
      n_clk = 8'd1;
      for (int i = 0; i < 3; i++) run_edge(10, 0, 1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_odd_and_max();
      n_clk = 8'd7;
      phase = 8'd128;
      run_edge(20, 3, 3, 1'b1, 1'b1, 1'b0);
      n_clk = 8'd255;
      phase = 8'd255;
      run_edge(400, 254, 127, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_unmeasured();
      n_clk = 8'd0;
      phase = 8'd64;
      for (int i = 0; i < 2; i++) run_edge(20, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      n_clk = 8'd100;
      phase = 8'd200;
      run_edge(40, 78, 50, 1'b1, 1'b0, 1'b0);
      run_edge(140, 78, 50, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_high();
      int     e;
      pulse_t p;
      n_clk = 8'd100;
      phase = 8'd64;
      sigIn = 1'b1;
      e = cyc + 1;
      p.start = e + 25 + LAT;
      p.len   = 11;
      exp_q.push_back(p);
      repeat (LAT + 36) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (sigOut !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got sigOut=%b busy=%b, expected 0 0", sigOut, busy);
      end
      sigIn = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      $display("reset pulsed during HIGH, E=%0d", e);
      run_edge(100, 25, 50, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_quarter_phase();
      test_zero_phase();
      test_odd_and_max();
      test_unmeasured();
      test_back_to_back();
      test_reset_mid_high();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL pulses_missing: got %0d unmatched expected pulses, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
